// File: rtl/writeback_buffer_if.sv
// Handshake, register-file write and forwarding signals of the writeback buffer.
// The master side is the producer/register file; the slave side is the buffer itself.
interface writeback_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_reg;
    logic [31:0]     in_data;
    logic            ctrl_stall;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [31:0]     data_writeReg;
    logic [4:0]      ctrl_readRegA;
    logic [4:0]      ctrl_readRegB;
    logic            fwd_hitA;
    logic            fwd_hitB;
    logic [31:0]     fwd_dataA;
    logic [31:0]     fwd_dataB;
    logic [CW-1:0]   wb_count;

    modport master (
        output in_valid, in_reg, in_data, ctrl_stall, ctrl_readRegA, ctrl_readRegB,
        input  in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, wb_count
    );

    modport slave (
        input  in_valid, in_reg, in_data, ctrl_stall, ctrl_readRegA, ctrl_readRegB,
        output in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, wb_count
    );
endinterface

// File: rtl/writeback_buffer.sv
// In-order writeback FIFO that drains one pending write per unstalled cycle into the
// register file and forwards the youngest pending value to the two snooped read ports.
module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    writeback_buffer_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    entryReg_r  [DEPTH];
    logic [31:0]   entryData_r [DEPTH];
    logic [PW-1:0] headPtr_r;
    logic [PW-1:0] tailPtr_r;
    logic [CW-1:0] count_r;

    logic          inReady_s;
    logic          enqStore_s;
    logic          deqFire_s;
    logic [4:0]    readReg_s  [2];
    logic          fwdHit_s   [2];
    logic [31:0]   fwdData_s  [2];
    logic [PW-1:0] fwdSlot_s;
    logic          fwdMatch_s;

    // Handshake and drain decisions; a register-0 write completes the handshake but is dropped.
    always_comb begin
        inReady_s  = (count_r < CW'(DEPTH));
        enqStore_s = wb.in_valid && inReady_s && (wb.in_reg != 5'd0);
        deqFire_s  = (count_r != {CW{1'b0}}) && !wb.ctrl_stall;
    end

    // Register-file write port, zeroed whenever the buffer is empty.
    always_comb begin
        wb.in_ready         = inReady_s;
        wb.ctrl_writeEnable = deqFire_s;
        wb.wb_count         = count_r;
        if (count_r != {CW{1'b0}}) begin
            wb.ctrl_writeReg = entryReg_r[headPtr_r];
            wb.data_writeReg = entryData_r[headPtr_r];
        end else begin
            wb.ctrl_writeReg = 5'd0;
            wb.data_writeReg = 32'd0;
        end
    end

    // Forwarding scan walks oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        readReg_s[0] = wb.ctrl_readRegA;
        readReg_s[1] = wb.ctrl_readRegB;
        fwdSlot_s    = headPtr_r;
        fwdMatch_s   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            fwdHit_s[p]  = 1'b0;
            fwdData_s[p] = 32'd0;
            for (int age = 0; age < DEPTH; age++) begin
                fwdSlot_s    = headPtr_r + PW'(age);
                fwdMatch_s   = (CW'(age) < count_r) && (readReg_s[p] != 5'd0) &&
                               (entryReg_r[fwdSlot_s] == readReg_s[p]);
                fwdHit_s[p]  = fwdHit_s[p] | fwdMatch_s;
                fwdData_s[p] = fwdMatch_s ? entryData_r[fwdSlot_s] : fwdData_s[p];
            end
        end
    end

    // Forwarding outputs.
    always_comb begin
        wb.fwd_hitA  = fwdHit_s[0];
        wb.fwd_dataA = fwdData_s[0];
        wb.fwd_hitB  = fwdHit_s[1];
        wb.fwd_dataB = fwdData_s[1];
    end

    // Pointer and occupancy state; reset discards every pending entry at once.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            headPtr_r <= {PW{1'b0}};
            tailPtr_r <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
        end else begin
            if (enqStore_s) begin
                tailPtr_r <= tailPtr_r + PW'(1);
            end
            if (deqFire_s) begin
                headPtr_r <= headPtr_r + PW'(1);
            end
            case ({enqStore_s, deqFire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage needs no reset: every consumer is qualified by the occupancy count.
    always_ff @(posedge clock) begin
        if (enqStore_s && !ctrl_reset) begin
            entryReg_r[tailPtr_r]  <= wb.in_reg;
            entryData_r[tailPtr_r] <= wb.in_data;
        end
    end
endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, the number of pending-write entries; legal values are 2, 4 and 8. CW = log2(DEPTH)+1.
- REQ-002 SHALL have port clock, input, 1, the single clock; all state updates occur on its rising edge.
- REQ-003 SHALL have port ctrl_reset, input, 1, the reset; it is asynchronous and active-high.
- REQ-004 SHALL have port in_valid, input, 1, meaning the producer offers a write.
- REQ-005 SHALL have port in_ready, output, 1, meaning the buffer can accept a write.
- REQ-006 SHALL have port in_reg, input, 5, the destination register of the offered write.
- REQ-007 SHALL have port in_data, input, 32, the data of the offered write.
- REQ-008 SHALL have port ctrl_stall, input, 1, which blocks draining when 1.
- REQ-009 SHALL have port ctrl_writeEnable, output, 1, the register file write enable.
- REQ-010 SHALL have port ctrl_writeReg, output, 5, the register file write address.
- REQ-011 SHALL have port data_writeReg, output, 32, the register file write data.
- REQ-012 SHALL have ports ctrl_readRegA and ctrl_readRegB, input, 5 each, the snooped register file read addresses.
- REQ-013 SHALL have ports fwd_hitA and fwd_hitB, output, 1 each, meaning a pending write matches the corresponding read address.
- REQ-014 SHALL have ports fwd_dataA and fwd_dataB, output, 32 each, the forwarded data for each read port.
- REQ-015 SHALL have port wb_count, output, CW, the number of valid entries.

Function
- REQ-016 SHALL be an in-order FIFO of DEPTH entries, each holding {reg[4:0], data[31:0]}, with a head pointer, a tail pointer (both modulo DEPTH, wrapping) and a count.
- REQ-017 SHALL drive in_ready = (count < DEPTH); in_ready SHALL NOT depend on a same-cycle dequeue.
- REQ-018 SHALL treat a write as accepted on an edge where in_valid && in_ready; it SHALL write the entry at the tail and advance the tail.
- REQ-019 SHALL accept a write with in_reg == 0 (handshake completes) but SHALL discard it: no entry is stored and count is unchanged.
- REQ-020 SHALL drive, combinationally from the head entry: ctrl_writeEnable = (count != 0) && !ctrl_stall, ctrl_writeReg = head.reg, data_writeReg = head.data.
- REQ-021 SHALL dequeue on every edge where ctrl_writeEnable == 1, so that the head write is committed to the register file on the same edge.
- REQ-022 SHALL give latency: a write accepted at edge N asserts ctrl_writeEnable in cycle N+1 (if it is at the head and not stalled) and commits at edge N+1.
- REQ-023 SHALL, on simultaneous enqueue and dequeue, store the new entry and retire the head, leaving count unchanged; with count == 1 this yields a correct back-to-back drain.
- REQ-024 SHALL hold all entries while ctrl_stall == 1; in_ready still follows REQ-017.
- REQ-025 SHALL drive ctrl_writeReg and data_writeReg to 0 when count == 0.
- REQ-026 SHALL set fwd_hitA = 1 when ctrl_readRegA != 0 and any valid entry has reg == ctrl_readRegA.
- REQ-027 SHALL drive fwd_dataA from the youngest matching entry (closest to the tail), and 0 when there is no hit.
- REQ-028 SHALL handle port B identically to port A (REQ-026, REQ-027).
- REQ-029 SHALL make forwarding purely combinational over the current valid entries: the entry being dequeued this cycle still forwards, and an in_* write not yet accepted does not.
- REQ-030 SHALL keep wb_count equal to the count register, ranging 0..DEPTH.

Reset
- REQ-031 SHALL, while ctrl_reset == 1 (asynchronously, at any point including mid-drain), clear the head pointer, tail pointer and count; in_ready = 1, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, fwd_hit* = 0, fwd_data* = 0, wb_count = 0.
- REQ-032 SHALL discard all pending entries on reset; entry storage need not be cleared, because every output is gated by count.
- REQ-033 SHALL accept no write on any edge while ctrl_reset == 1.

Verification
- REQ-034 SHALL cover: reset, then accept (r5, 0xDEADBEEF) -> next cycle ctrl_writeEnable = 1, ctrl_writeReg = 5, data_writeReg = 0xDEADBEEF; wb_count 1 -> 0 after the edge.
- REQ-035 SHALL cover: ctrl_stall = 1 with four writes r1..r4 = 0x11..0x44 -> wb_count = 4, in_ready = 0; a fifth offer is not accepted; release the stall -> r1..r4 are written in order on 4 consecutive edges.
- REQ-036 SHALL cover: stalled entries (r7, 0xA) then (r7, 0xB), with ctrl_readRegA = 7 and ctrl_readRegB = 7 -> fwd_hitA = fwd_hitB = 1 and fwd_dataA = fwd_dataB = 0xB; ctrl_readRegA = 0 -> fwd_hitA = 0.
- REQ-037 SHALL cover: offer (r0, 0xFFFFFFFF) -> in_ready handshake completes, wb_count stays 0, ctrl_writeEnable stays 0.
- REQ-038 SHALL cover: a continuous stream of 10 writes with no stall -> one commit per edge, pointers wrap past DEPTH, and wb_count never exceeds 1.
- REQ-039 SHALL cover: ctrl_reset pulsed asynchronously between edges while wb_count = 3 -> all outputs take their reset values immediately and no further commits occur.
